// File: rtl/hypot_sched.sv
// hypot_sched
// Round-robin front end that shares one multi-cycle hypotenuse engine
// between NREQ requesters. Only one operation is in flight at any time.
// The engine runs under a watchdog. The result, or a zero result with
// resp_err set after a watchdog abort, goes back to the granted requester.
//
// Parameters:
//   NREQ    - number of requesters (2..8)
//   W       - operand and result width
//   TIMEOUT - maximum number of cycles spent in WAIT before aborting (>= 2)
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/req_ready    - per-requester operand handshake (ready is one-hot or zero)
//   req_x, req_y           - packed operands, requester i at [i*W +: W]
//   resp_valid/resp_ready  - per-requester response handshake (valid is one-hot or zero)
//   resp_data, resp_err    - shared result and watchdog-abort flag
//   eng_start              - one-cycle engine launch pulse
//   eng_x, eng_y           - registered engine operands
//   eng_done, eng_result   - engine completion pulse and result
//   busy                   - scheduler is not idle
//   grant_id               - current or most recent granted requester

module hypot_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W-1:0]         req_x,
    input  logic [NREQ*W-1:0]         req_y,
    output logic [NREQ-1:0]           resp_valid,
    input  logic [NREQ-1:0]           resp_ready,
    output logic [W-1:0]              resp_data,
    output logic                      resp_err,
    output logic                      eng_start,
    output logic [W-1:0]              eng_x,
    output logic [W-1:0]              eng_y,
    input  logic                      eng_done,
    input  logic [W-1:0]              eng_result,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [NREQ-1:0] ONE_HOT_BASE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [GW-1:0] last_grant;
    logic [GW-1:0] sel;
    logic          sel_found;
    logic [CW-1:0] wd_cnt;
    logic          timeout_hit;
    logic          accept;
    logic          resp_fire;

    // Round-robin pick: scan upward starting just after the last served
    // requester. The last served requester is therefore checked last.
    // Only the pointer and the current req_valid vector affect the pick.
    always_comb begin : arb
        int            idx;
        logic [GW-1:0] idx_g;
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        idx_g     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx   = (int'(last_grant) + i) % NREQ;
            idx_g = GW'(idx);
            if (!sel_found && req_valid[idx_g]) begin
                sel       = idx_g;
                sel_found = 1'b1;
            end
        end
    end

    assign accept      = (state == IDLE) && sel_found;
    assign resp_fire   = (state == RESP) && resp_ready[grant_id];
    assign timeout_hit = (wd_cnt == CW'(TIMEOUT - 1));

    // These outputs decode the state register directly. A reset therefore
    // drops eng_start and resp_valid at once, without waiting for a clock.
    assign req_ready  = accept ? (ONE_HOT_BASE << sel) : '0;
    assign resp_valid = (state == RESP) ? (ONE_HOT_BASE << grant_id) : '0;
    assign eng_start  = (state == LAUNCH);
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In WAIT, eng_done is checked before the watchdog,
    // so eng_done wins when both happen in the same cycle. eng_done has no
    // effect in any other state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (eng_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. eng_x and eng_y are loaded only on accept, so they
    // hold steady from LAUNCH through RESP. last_grant moves only when the
    // response is taken, which sets where the next round-robin scan starts.
    // The watchdog is cleared in LAUNCH and stops at TIMEOUT-1, so it never
    // wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_x      <= '0;
            eng_y      <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
            wd_cnt     <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_x    <= req_x[int'(sel)*W +: W];
                        eng_y    <= req_y[int'(sel)*W +: W];
                        grant_id <= sel;
                    end
                end
                LAUNCH: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (eng_done) begin
                        resp_data <= eng_result;
                        resp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        last_grant <= grant_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
